dma_bus_arbiter: RTL and testbench

- Arbitrates the shared 32-bit memory address bus between the CPU fetch/data path and the DMA module, using a HOLD/HLDA handshake.
- Drives the address-source select (0 = CPU, 1 = DMA) and a registered bus address/valid pair into memory.
- Limits DMA burst length and enforces a CPU-only slot after a forced release, so neither requester starves.

---
 rtl/dma_bus_arbiter_pkg.sv | 19 +
 rtl/arb_slot_counter.sv | 29 ++
 rtl/dma_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter: state encoding,
// address-source select values and default burst/cooldown sizing.
package dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        CPU_OWN,
        DRAIN,
        DMA_OWN,
        RETURN,
        COOLDOWN
    } arb_state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    localparam int unsigned DEF_MAX_BURST = 16;
    localparam int unsigned DEF_CPU_SLOT  = 4;

endpackage

// File: rtl/arb_slot_counter.sv
// Loadable up/down counter; tc flags when the count equals the term value.
module arb_slot_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU/DMA shared address bus arbiter with HOLD/HLDA handshake, DMA burst
// limit and post-preemption CPU slot. Optional macro: ARB_STATS_EN.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned CPU_SLOT  = DEF_CPU_SLOT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              dma_hold,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_done,
    output logic              cpu_ack,
    output logic              dma_hlda,
    output logic              sel_direccion,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_valid,
    output logic [15:0]       dma_busy_cycles
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned SLOT_W  = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;

    arb_state_t        state, state_nxt;
    logic              preempt, preempt_nxt;
    logic              ack_nxt, hlda_nxt, sel_nxt, valid_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              burst_load, burst_en, burst_tc;
    logic              slot_load, slot_en, slot_tc;

    arb_slot_counter #(.W(BURST_W)) u_burst_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (burst_load),
        .load_val (BURST_W'(1)),
        .en       (burst_en),
        .up       (1'b1),
        .term     (BURST_W'(MAX_BURST)),
        .tc       (burst_tc)
    );

    // Loaded with CPU_SLOT on entry; the last cooldown cycle sees count == 1.
    arb_slot_counter #(.W(SLOT_W)) u_cooldown_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slot_load),
        .load_val (SLOT_W'(CPU_SLOT)),
        .en       (slot_en),
        .up       (1'b0),
        .term     (SLOT_W'(1)),
        .tc       (slot_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CPU_OWN;
            preempt       <= 1'b0;
            cpu_ack       <= 1'b0;
            dma_hlda      <= 1'b0;
            sel_direccion <= SEL_CPU;
            bus_addr      <= '0;
            bus_valid     <= 1'b0;
        end else begin
            state         <= state_nxt;
            preempt       <= preempt_nxt;
            cpu_ack       <= ack_nxt;
            dma_hlda      <= hlda_nxt;
            sel_direccion <= sel_nxt;
            bus_addr      <= addr_nxt;
            bus_valid     <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        preempt_nxt = preempt;
        ack_nxt     = 1'b0;
        hlda_nxt    = 1'b0;
        sel_nxt     = SEL_CPU;
        addr_nxt    = bus_addr;
        valid_nxt   = 1'b0;
        burst_load  = 1'b0;
        burst_en    = 1'b0;
        slot_load   = 1'b0;
        slot_en     = 1'b0;

        case (state)
            CPU_OWN: begin
                ack_nxt   = cpu_req;
                valid_nxt = cpu_req;
                addr_nxt  = cpu_addr;
                if (dma_hold) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (dma_hold) begin
                    state_nxt  = DMA_OWN;
                    hlda_nxt   = 1'b1;
                    sel_nxt    = SEL_DMA;
                    addr_nxt   = dma_addr;
                    valid_nxt  = 1'b1;
                    burst_load = 1'b1;
                end else begin
                    state_nxt = CPU_OWN;
                end
            end
            DMA_OWN: begin
                if (!dma_hold || dma_done) begin
                    state_nxt = RETURN;
                end else if (burst_tc) begin
                    state_nxt   = RETURN;
                    preempt_nxt = 1'b1;
                end else begin
                    hlda_nxt  = 1'b1;
                    sel_nxt   = SEL_DMA;
                    addr_nxt  = dma_addr;
                    valid_nxt = 1'b1;
                    burst_en  = 1'b1;
                end
            end
            RETURN: begin
                if (preempt && (CPU_SLOT > 0)) begin
                    state_nxt = COOLDOWN;
                    slot_load = 1'b1;
                end else begin
                    state_nxt   = CPU_OWN;
                    preempt_nxt = 1'b0;
                end
            end
            COOLDOWN: begin
                ack_nxt   = cpu_req;
                valid_nxt = cpu_req;
                addr_nxt  = cpu_addr;
                slot_en   = 1'b1;
                if (slot_tc) begin
                    state_nxt   = CPU_OWN;
                    preempt_nxt = 1'b0;
                end
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

`ifdef ARB_STATS_EN
    logic [15:0] busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (dma_hlda && (busy_cnt != 16'hFFFF)) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    assign dma_busy_cycles = busy_cnt;
`else
    assign dma_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with MAX_BURST = 4, CPU_SLOT = 4;
// expected values are hand-derived cycle by cycle.
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        dma_hold;
    logic [31:0] dma_addr;
    logic        dma_done;
    logic        cpu_ack;
    logic        dma_hlda;
    logic        sel_direccion;
    logic [31:0] bus_addr;
    logic        bus_valid;
    logic [15:0] dma_busy_cycles;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    dma_bus_arbiter #(
        .ADDR_W    (32),
        .MAX_BURST (4),
        .CPU_SLOT  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .dma_hold        (dma_hold),
        .dma_addr        (dma_addr),
        .dma_done        (dma_done),
        .cpu_ack         (cpu_ack),
        .dma_hlda        (dma_hlda),
        .sel_direccion   (sel_direccion),
        .bus_addr        (bus_addr),
        .bus_valid       (bus_valid),
        .dma_busy_cycles (dma_busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        check_eq("sel_eq_hlda", {31'b0, sel_direccion}, {31'b0, dma_hlda});
        check_eq("ack_hlda_excl", {31'b0, cpu_ack & dma_hlda}, 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] stats_exp;
`ifdef ARB_STATS_EN
        stats_exp = 16'd4;
`else
        stats_exp = 16'd0;
`endif
        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        dma_hold = 1'b0; dma_addr = '0; dma_done = 1'b0;
        step(); step();
        check_eq("rst_ack",   {31'b0, cpu_ack},   32'd0);
        check_eq("rst_hlda",  {31'b0, dma_hlda},  32'd0);
        check_eq("rst_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("rst_addr",  bus_addr,           32'd0);
        check_eq("rst_stats", {16'b0, dma_busy_cycles}, 32'd0);
        rst_n = 1'b1;

        // CPU only
        cpu_req = 1'b1; cpu_addr = 32'h100;
        step();
        check_eq("cpu_addr",  bus_addr,           32'h100);
        check_eq("cpu_valid", {31'b0, bus_valid}, 32'd1);
        check_eq("cpu_ack",   {31'b0, cpu_ack},   32'd1);
        check_eq("cpu_sel",   {31'b0, sel_direccion}, 32'd0);
        cpu_req = 1'b0;
        step();
        check_eq("cpu_idle_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("cpu_idle_ack",   {31'b0, cpu_ack},   32'd0);

        // Burst limit: simultaneous CPU request and hold at E0
        cpu_req = 1'b1; cpu_addr = 32'h200; dma_hold = 1'b1; dma_addr = 32'hA000;
        step();
        check_eq("e0_ack",  {31'b0, cpu_ack},  32'd1);
        check_eq("e0_addr", bus_addr,          32'h200);
        check_eq("e0_hlda", {31'b0, dma_hlda}, 32'd0);
        cpu_req = 1'b0;
        step();
        check_eq("e1_hlda",  {31'b0, dma_hlda},  32'd1);
        check_eq("e1_valid", {31'b0, bus_valid}, 32'd1);
        check_eq("e1_addr",  bus_addr,           32'hA000);
        for (int i = 1; i <= 3; i++) begin
            dma_addr = 32'hA000 + 32'(4 * i);
            step();
            check_eq("burst_hlda", {31'b0, dma_hlda}, 32'd1);
            check_eq("burst_addr", bus_addr, 32'hA000 + 32'(4 * i));
        end
        dma_addr = 32'hA010;
        step();
        check_eq("limit_hlda",  {31'b0, dma_hlda},  32'd0);
        check_eq("limit_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("stats_burst", {16'b0, dma_busy_cycles}, {16'b0, stats_exp});
        cpu_req = 1'b1; cpu_addr = 32'h300;
        step();
        check_eq("ret_ack",   {31'b0, cpu_ack},   32'd0);
        check_eq("ret_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("ret_hlda",  {31'b0, dma_hlda},  32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("cool_hlda", {31'b0, dma_hlda}, 32'd0);
            check_eq("cool_ack",  {31'b0, cpu_ack},  32'd1);
            check_eq("cool_addr", bus_addr,          32'h300);
        end
        cpu_req = 1'b0;
        step();
        check_eq("post_cool_hlda", {31'b0, dma_hlda}, 32'd0);
        check_eq("post_cool_ack",  {31'b0, cpu_ack},  32'd0);
        step();
        check_eq("regrant_hlda", {31'b0, dma_hlda}, 32'd1);
        check_eq("regrant_addr", bus_addr,          32'hA010);

        // Early done after 2 transfers: no cooldown follows
        dma_addr = 32'hB000;
        step();
        check_eq("early_t2_hlda", {31'b0, dma_hlda}, 32'd1);
        check_eq("early_t2_addr", bus_addr,          32'hB000);
        dma_done = 1'b1;
        step();
        check_eq("done_hlda",  {31'b0, dma_hlda},  32'd0);
        check_eq("done_valid", {31'b0, bus_valid}, 32'd0);
        dma_done = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h400;
        step();
        check_eq("done_ret_ack", {31'b0, cpu_ack}, 32'd0);
        step();
        check_eq("done_cpu_ack",  {31'b0, cpu_ack},  32'd1);
        check_eq("done_cpu_addr", bus_addr,          32'h400);
        check_eq("done_cpu_hlda", {31'b0, dma_hlda}, 32'd0);
        cpu_req = 1'b0;
        step();
        check_eq("done_regrant_hlda", {31'b0, dma_hlda}, 32'd1);

        // Asynchronous reset in the middle of DMA ownership
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_hlda",  {31'b0, dma_hlda},      32'd0);
        check_eq("arst_sel",   {31'b0, sel_direccion}, 32'd0);
        check_eq("arst_valid", {31'b0, bus_valid},     32'd0);
        check_eq("arst_addr",  bus_addr,               32'd0);
        check_eq("arst_stats", {16'b0, dma_busy_cycles}, 32'd0);
        dma_hold = 1'b0;
        #2 rst_n = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h500;
        step();
        check_eq("arst_cpu_ack",  {31'b0, cpu_ack}, 32'd1);
        check_eq("arst_cpu_addr", bus_addr,         32'h500);

        // Hold withdrawn during DRAIN
        cpu_addr = 32'h600; dma_hold = 1'b1;
        step();
        check_eq("abort_pre_valid", {31'b0, bus_valid}, 32'd1);
        dma_hold = 1'b0;
        step();
        check_eq("abort_drain_valid", {31'b0, bus_valid}, 32'd0);
        check_eq("abort_drain_hlda",  {31'b0, dma_hlda},  32'd0);
        step();
        check_eq("abort_back_valid", {31'b0, bus_valid}, 32'd1);
        check_eq("abort_back_ack",   {31'b0, cpu_ack},   32'd1);
        check_eq("abort_back_hlda",  {31'b0, dma_hlda},  32'd0);
        cpu_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
